ps2_keypad_rx: RTL and testbench

- Parametrised PS/2 keyboard receiver that replaces the single-codeword keypad decoder.
- Synchronises PS2_CLK/PS2_DATA and frames 11-bit packets with start, stop and odd-parity checks.
- Runs a prefix state machine for E0 (extended) and F0 (break), maps keypad scancodes to 5-bit tokens, suppresses typematic repeats, and buffers events in a FIFO with a valid/ready interface toward the calculator datapath.

---
 rtl/ps2_keypad_rx_if.sv | 20 ++
 rtl/ps2_keypad_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_ps2_keypad_rx.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keypad_rx_if.sv
// Keypad event stream from the PS/2 receiver to the calculator datapath.
// The master holds the FIFO head and the slave accepts it with KEY_READY.
interface ps2_keypad_rx_if;
    logic       KEY_VALID;
    logic       KEY_READY;
    logic [4:0] KEY_TOKEN;
    logic       KEY_BREAK;
    logic       KEY_EXT;
    logic [7:0] KEY_RAW;

    modport master (
        output KEY_VALID, KEY_TOKEN, KEY_BREAK, KEY_EXT, KEY_RAW,
        input  KEY_READY
    );

    modport slave (
        input  KEY_VALID, KEY_TOKEN, KEY_BREAK, KEY_EXT, KEY_RAW,
        output KEY_READY
    );
endinterface

// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver: frames packets, decodes E0/F0 prefixes, maps keypad
// scancodes to tokens, filters typematic repeats and buffers events in a FIFO.
module ps2_keypad_rx #(
    parameter int CLK_DIV         = 250,
    parameter int TIMEOUT_TICKS   = 4000,
    parameter int FIFO_DEPTH      = 4,
    parameter bit REPEAT_SUPPRESS = 1'b1,
    parameter bit PASS_UNMAPPED   = 1'b0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            PS2_CLK,
    input  logic            PS2_DATA,
    ps2_keypad_rx_if.master key,
    output logic            PARITY_ERR,
    output logic            OVERFLOW
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef struct packed {
        logic [4:0] token;
        logic       brk;
        logic       ext;
        logic [7:0] raw;
    } event_t;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} dec_state_t;

    function automatic logic [4:0] map_token(input logic [7:0] code);
        case (code)
            8'h70: map_token = 5'd0;
            8'h69: map_token = 5'd1;
            8'h72: map_token = 5'd2;
            8'h7A: map_token = 5'd3;
            8'h6B: map_token = 5'd4;
            8'h73: map_token = 5'd5;
            8'h74: map_token = 5'd6;
            8'h6C: map_token = 5'd7;
            8'h75: map_token = 5'd8;
            8'h7D: map_token = 5'd9;
            8'h79: map_token = 5'd10;
            8'h7B: map_token = 5'd11;
            8'h7C: map_token = 5'd12;
            8'h4A: map_token = 5'd13;
            8'h5A: map_token = 5'd14;
            8'h76: map_token = 5'd15;
            default: map_token = 5'd16;
        endcase
    endfunction

    // Two-flop synchronisers, preset high to match an idle PS/2 bus.
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       ps2_clk_s;
    logic       ps2_dat_s;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
        end
    end

    assign ps2_clk_s = clk_sync[1];
    assign ps2_dat_s = dat_sync[1];

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // Bit capture and frame timeout, all advanced on the sample tick.
    logic            clk_prev;
    logic [10:0]     shreg;
    logic [3:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            fall;
    logic            frame_done;
    logic            frame_good;
    logic [7:0]      data_byte;

    assign fall       = tick && clk_prev && !ps2_clk_s;
    assign frame_done = tick && (bit_cnt == 4'd11);
    assign frame_good = !shreg[0] && shreg[10] && (^shreg[9:1]);
    assign data_byte  = shreg[8:1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_prev <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
        end else if (tick) begin
            clk_prev <= ps2_clk_s;
            if (bit_cnt == 4'd11) begin
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else if (fall) begin
                shreg   <= {ps2_dat_s, shreg[10:1]};
                bit_cnt <= bit_cnt + 1'b1;
                to_cnt  <= '0;
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    // Prefix decoder, held-key tracking and event staging register.
    dec_state_t state;
    logic [15:0] held;
    logic        ev_vld;
    event_t      ev;
    logic        is_e0;
    logic        is_f0;
    logic        emit_now;
    logic        brk_now;
    logic        ext_now;
    logic [4:0]  tok_map;
    logic        tracked;
    logic        keep;

    assign is_e0    = (data_byte == 8'hE0);
    assign is_f0    = (data_byte == 8'hF0);
    assign emit_now = frame_done && frame_good && !is_e0 && !is_f0;
    assign brk_now  = (state == BRK) || (state == EXTBRK);
    assign ext_now  = (state == EXT) || (state == EXTBRK);
    assign tok_map  = map_token(data_byte);
    assign tracked  = !tok_map[4];

    always_comb begin
        keep = 1'b0;
        if (emit_now) begin
            if (!tracked)
                keep = PASS_UNMAPPED;
            else
                keep = brk_now || !(REPEAT_SUPPRESS && held[tok_map[3:0]]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            held       <= '0;
            ev_vld     <= 1'b0;
            ev         <= '0;
            PARITY_ERR <= 1'b0;
        end else begin
            ev_vld     <= keep;
            PARITY_ERR <= frame_done && !frame_good;
            if (keep) ev <= '{token: tok_map, brk: brk_now, ext: ext_now, raw: data_byte};
            if (emit_now && tracked) held[tok_map[3:0]] <= !brk_now;
            if (frame_done) begin
                if (!frame_good) begin
                    state <= IDLE;
                end else if (is_e0) begin
                    case (state)
                        IDLE, EXT: state <= EXT;
                        default:   state <= state;
                    endcase
                end else if (is_f0) begin
                    case (state)
                        IDLE:    state <= BRK;
                        EXT:     state <= EXTBRK;
                        default: state <= state;
                    endcase
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    // Event FIFO; the head is re-registered every cycle from the next-state pointers.
    event_t         mem [FIFO_DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  rptr_nx;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nx;
    logic           valid_q;
    event_t         head_q;
    logic           pop;
    logic           full;
    logic           do_push;

    assign pop      = valid_q && key.KEY_READY;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign do_push  = ev_vld && (!full || pop);
    assign count_nx = count + CW'(do_push) - CW'(pop);
    assign rptr_nx  = rptr + AW'(pop);

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= ev;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            OVERFLOW <= ev_vld && full && !pop;
            if (do_push) wptr <= wptr + 1'b1;
            rptr  <= rptr_nx;
            count <= count_nx;
            if (count_nx == '0) begin
                valid_q <= 1'b0;
                head_q  <= '0;
            end else begin
                valid_q <= 1'b1;
                // A push into a FIFO that is empty after this pop becomes the head directly.
                head_q  <= (do_push && (count - CW'(pop)) == '0) ? ev : mem[rptr_nx];
            end
        end
    end

    assign key.KEY_VALID = valid_q;
    assign key.KEY_TOKEN = head_q.token;
    assign key.KEY_BREAK = head_q.brk;
    assign key.KEY_EXT   = head_q.ext;
    assign key.KEY_RAW   = head_q.raw;
endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Bench for ps2_keypad_rx: directed vector table, corner-case sequences and
// randomized byte streams checked against a prefix/held-key reference model.
module tb_ps2_keypad_rx;
    localparam int CLK_DIV = 4;
    localparam int HALF    = 12;

    logic CLK      = 1'b0;
    logic RST_N    = 1'b0;
    logic PS2_CLK  = 1'b1;
    logic PS2_DATA = 1'b1;
    logic PARITY_ERR;
    logic OVERFLOW;

    ps2_keypad_rx_if kif();

    ps2_keypad_rx #(.CLK_DIV(CLK_DIV)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .key        (kif.master),
        .PARITY_ERR (PARITY_ERR),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    logic [14:0] got[$];
    logic [14:0] exp_q[$];
    int perr_cnt = 0;
    int ovf_cnt  = 0;
    int rdy_mode = 1;

    // Consumer: 0 = stall, 1 = always ready, 2 = random backpressure.
    initial begin
        kif.KEY_READY = 1'b0;
        forever begin
            @(posedge CLK); #1;
            case (rdy_mode)
                0:       kif.KEY_READY = 1'b0;
                1:       kif.KEY_READY = 1'b1;
                default: kif.KEY_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            if (kif.KEY_VALID && kif.KEY_READY)
                got.push_back({kif.KEY_TOKEN, kif.KEY_BREAK, kif.KEY_EXT, kif.KEY_RAW});
            if (PARITY_ERR) perr_cnt++;
            if (OVERFLOW)   ovf_cnt++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Reference model: E0/F0 flags, held-key bitmap, expected event queue.
    logic [7:0]  codes [16];
    logic [4:0]  map_tab [256];
    bit          m_e0, m_f0;
    bit [15:0]   m_held;

    task automatic model_byte(input logic [7:0] b);
        logic [4:0] t;
        if (b == 8'hE0) begin
            if (!m_f0) m_e0 = 1'b1;
        end else if (b == 8'hF0) begin
            m_f0 = 1'b1;
        end else begin
            t = map_tab[b];
            if (t != 5'd16) begin
                if (m_f0) begin
                    m_held[t[3:0]] = 1'b0;
                    exp_q.push_back({t, 1'b1, m_e0, b});
                end else if (!m_held[t[3:0]]) begin
                    m_held[t[3:0]] = 1'b1;
                    exp_q.push_back({t, 1'b0, m_e0, b});
                end
            end
            m_e0 = 1'b0;
            m_f0 = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_e0 = 1'b0; m_f0 = 1'b0; m_held = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DATA = b;
        clks(HALF);
        PS2_CLK = 1'b0;
        clks(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~(^d)) ^ bad, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        PS2_DATA = 1'b1;
        clks(2 * HALF);
        if (nbits == 11) begin
            if (bad) begin m_e0 = 1'b0; m_f0 = 1'b0; end
            else model_byte(d);
        end
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b0, 11);
    endtask

    typedef struct packed {
        logic [23:0] by;
        logic [1:0]  n;
        logic        ev;
        logic [14:0] e;
    } vec_t;

    function automatic vec_t mk(input logic [23:0] by, input int n, input bit ev,
                                input logic [4:0] tok, input bit brk, input bit ext,
                                input logic [7:0] raw);
        vec_t v;
        v.by = by; v.n = 2'(n); v.ev = ev; v.e = {tok, brk, ext, raw};
        return v;
    endfunction

    vec_t tab [18];

    initial begin
        logic [23:0] by;
        logic [7:0]  b;
        int          r, p0, o0, nbad;
        bit          bad;

        codes = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                  8'h75, 8'h7D, 8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h5A, 8'h76};
        for (int i = 0; i < 256; i++) map_tab[i] = 5'd16;
        for (int i = 0; i < 16; i++) map_tab[codes[i]] = 5'(i);
        model_reset();

        tab[0]  = mk(24'h690000, 1, 1,  1, 0, 0, 8'h69);
        tab[1]  = mk(24'hF06900, 2, 1,  1, 1, 0, 8'h69);
        tab[2]  = mk(24'hE05A00, 2, 1, 14, 0, 1, 8'h5A);
        tab[3]  = mk(24'hE0F05A, 3, 1, 14, 1, 1, 8'h5A);
        tab[4]  = mk(24'h700000, 1, 1,  0, 0, 0, 8'h70);
        tab[5]  = mk(24'h700000, 1, 0,  0, 0, 0, 8'h70);
        tab[6]  = mk(24'hF07000, 2, 1,  0, 1, 0, 8'h70);
        tab[7]  = mk(24'h7C0000, 1, 1, 12, 0, 0, 8'h7C);
        tab[8]  = mk(24'hF07C00, 2, 1, 12, 1, 0, 8'h7C);
        tab[9]  = mk(24'h150000, 1, 0,  0, 0, 0, 8'h00);
        tab[10] = mk(24'hF01500, 2, 0,  0, 0, 0, 8'h00);
        tab[11] = mk(24'hE04A00, 2, 1, 13, 0, 1, 8'h4A);
        tab[12] = mk(24'hE0F04A, 3, 1, 13, 1, 1, 8'h4A);
        tab[13] = mk(24'hF07600, 2, 1, 15, 1, 0, 8'h76);
        tab[14] = mk(24'hE0E06B, 3, 1,  4, 0, 1, 8'h6B);
        tab[15] = mk(24'hF0F06B, 3, 1,  4, 1, 0, 8'h6B);
        tab[16] = mk(24'hE05A00, 2, 1, 14, 0, 1, 8'h5A);
        tab[17] = mk(24'hF0E05A, 3, 1, 14, 1, 0, 8'h5A);

        clks(5);
        chk("reset KEY_VALID",  32'(kif.KEY_VALID), 0);
        chk("reset KEY_TOKEN",  32'(kif.KEY_TOKEN), 0);
        chk("reset KEY_BREAK",  32'(kif.KEY_BREAK), 0);
        chk("reset KEY_EXT",    32'(kif.KEY_EXT),   0);
        chk("reset KEY_RAW",    32'(kif.KEY_RAW),   0);
        chk("reset PARITY_ERR", 32'(PARITY_ERR),    0);
        chk("reset OVERFLOW",   32'(OVERFLOW),      0);
        RST_N = 1'b1;
        clks(10);

        for (int k = 0; k < 18; k++) begin
            got.delete();
            by = tab[k].by;
            for (int j = 0; j < int'(tab[k].n); j++) begin
                send(by[23:16]);
                by = by << 8;
            end
            clks(20);
            chk($sformatf("vec%0d count", k), 32'(got.size()), 32'(tab[k].ev));
            if (tab[k].ev && got.size() > 0)
                chk($sformatf("vec%0d event", k), 32'(got[0]), 32'(tab[k].e));
        end

        // Typematic repeat: three makes then a break give two events.
        got.delete();
        send(8'h7D); send(8'h7D); send(8'h7D); send(8'hF0); send(8'h7D);
        clks(20);
        chk("repeat count", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("repeat make",  32'(got[0]), 32'({5'd9, 1'b0, 1'b0, 8'h7D}));
            chk("repeat break", 32'(got[1]), 32'({5'd9, 1'b1, 1'b0, 8'h7D}));
        end

        // Bad parity, then the same code with good parity.
        got.delete();
        p0 = perr_cnt;
        send_frame(8'h70, 1'b1, 11);
        clks(20);
        chk("parity pulses", 32'(perr_cnt - p0), 1);
        chk("parity no event", 32'(got.size()), 0);
        send(8'h70);
        clks(20);
        chk("after parity count", 32'(got.size()), 1);
        if (got.size() > 0) chk("after parity event", 32'(got[0]), 32'({5'd0, 1'b0, 1'b0, 8'h70}));
        send(8'hF0); send(8'h70);

        // Partial frame abandoned by timeout.
        clks(20);
        got.delete();
        p0 = perr_cnt;
        send_frame(8'h73, 1'b0, 6);
        clks(4000 * CLK_DIV + 400);
        send(8'h73);
        clks(20);
        chk("timeout no perr", 32'(perr_cnt - p0), 0);
        chk("timeout count", 32'(got.size()), 1);
        if (got.size() > 0) chk("timeout event", 32'(got[0]), 32'({5'd5, 1'b0, 1'b0, 8'h73}));
        send(8'hF0); send(8'h73);

        // Overflow with a stalled consumer, then drain in order.
        clks(20);
        got.delete();
        rdy_mode = 0;
        clks(4);
        o0 = ovf_cnt;
        send(8'h69); send(8'h72); send(8'h7A); send(8'h6B); send(8'h73);
        clks(20);
        chk("overflow pulses", 32'(ovf_cnt - o0), 1);
        chk("stall no pops", 32'(got.size()), 0);
        chk("stall head valid", 32'(kif.KEY_VALID), 1);
        chk("stall head token", 32'(kif.KEY_TOKEN), 1);
        rdy_mode = 1;
        clks(20);
        chk("drain count", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++)
            if (got.size() > i)
                chk($sformatf("drain %0d", i), 32'(got[i]), 32'({5'(i + 1), 1'b0, 1'b0, codes[i + 1]}));
        chk("drained valid", 32'(kif.KEY_VALID), 0);

        // Reset in the middle of a frame with an event pending.
        rdy_mode = 0;
        clks(4);
        send(8'h7C);
        clks(10);
        chk("pre-reset valid", 32'(kif.KEY_VALID), 1);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        RST_N = 1'b0;
        #1;
        chk("midreset outputs", 32'({kif.KEY_VALID, kif.KEY_TOKEN, kif.KEY_BREAK, kif.KEY_EXT,
                                     kif.KEY_RAW, PARITY_ERR, OVERFLOW}), 0);
        model_reset();
        clks(3);
        RST_N = 1'b1;
        rdy_mode = 1;
        clks(10);
        got.delete();
        p0 = perr_cnt;
        send(8'h73);
        clks(20);
        chk("post-reset no perr", 32'(perr_cnt - p0), 0);
        chk("post-reset count", 32'(got.size()), 1);
        if (got.size() > 0) chk("post-reset event", 32'(got[0]), 32'({5'd5, 1'b0, 1'b0, 8'h73}));

        // Randomized byte stream with backpressure and occasional bad frames.
        got.delete();
        exp_q.delete();
        p0 = perr_cnt;
        o0 = ovf_cnt;
        nbad = 0;
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 21);
            if (r < 16)       b = codes[r];
            else if (r < 18)  b = 8'hE0;
            else if (r < 20)  b = 8'hF0;
            else if (r == 20) b = 8'h15;
            else              b = 8'h1C;
            bad = ($urandom_range(0, 11) == 0);
            if (bad) nbad++;
            send_frame(b, bad, 11);
        end
        rdy_mode = 1;
        clks(50);
        chk("random event count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("random ev%0d", i), 32'(got[i]), 32'(exp_q[i]));
        chk("random perr", 32'(perr_cnt - p0), 32'(nbad));
        chk("random no overflow", 32'(ovf_cnt - o0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
